// File: rtl/sched_pkg.sv
// Shared types for the EDF scheduler and its CPU-facing dispatch controller.
package sched_pkg;

  localparam int MAX_TASKS_DEF = 8;
  localparam int TASK_ID_BITS  = $clog2(MAX_TASKS_DEF);
  localparam int TIME_BITS     = 8;

  typedef enum logic [1:0] {
    TASK_PERIODIC  = 2'd0,
    TASK_SPORADIC  = 2'd1,
    TASK_APERIODIC = 2'd2
  } task_type_t;

  typedef enum logic {
    CRIT_LO = 1'b0,
    CRIT_HI = 1'b1
  } task_crit_in_t;

  typedef struct packed {
    logic                    valid;
    logic [TASK_ID_BITS-1:0] id;
    task_type_t              task_type;
    task_crit_in_t           crit;
    logic [TIME_BITS-1:0]    period;
    logic [TIME_BITS-1:0]    deadline;
    logic [TIME_BITS-1:0]    wcet;
  } task_table_input_t;

  typedef enum logic [1:0] {
    DISP_IDLE      = 2'd0,
    DISP_REQ       = 2'd1,
    DISP_RUN       = 2'd2,
    DISP_DONE_WAIT = 2'd3
  } disp_state_t;

endpackage

// File: rtl/sched_wakeup_arb.sv
// Merges mapped IRQ rising edges and software wakeups into one registered
// scheduler wakeup per cycle; software wins, IRQs are served round-robin.
module sched_wakeup_arb #(
  parameter int NUM_IRQ   = 8,
  parameter int TASK_BITS = 3,
  localparam int IRQ_BITS = $clog2(NUM_IRQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq_lines_i,
  input  logic                 map_we_i,
  input  logic [IRQ_BITS-1:0]  map_idx_i,
  input  logic                 map_en_i,
  input  logic [TASK_BITS-1:0] map_id_i,
  input  logic                 sw_wake_valid_i,
  input  logic [TASK_BITS-1:0] sw_wake_id_i,
  output logic                 wake_valid_o,
  output logic [TASK_BITS-1:0] wake_id_o
);

  logic [NUM_IRQ-1:0]   irq_q, pending_q, pending_d, map_en_q;
  logic [NUM_IRQ-1:0]   rise, eligible;
  logic [TASK_BITS-1:0] map_id_q [NUM_IRQ];
  logic [IRQ_BITS-1:0]  rr_q, rr_d, grant_idx;
  logic                 grant_any;
  logic                 wake_valid_q, wake_valid_d;
  logic [TASK_BITS-1:0] wake_id_q, wake_id_d;

  assign rise     = irq_lines_i & ~irq_q & map_en_q;
  assign eligible = pending_q | rise;

  // Scan downward so the lowest offset from rr_q is the one left standing.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_q) + k) % NUM_IRQ]) begin
        grant_any = 1'b1;
        grant_idx = IRQ_BITS'((int'(rr_q) + k) % NUM_IRQ);
      end
    end
  end

  always_comb begin
    pending_d    = eligible;
    rr_d         = rr_q;
    wake_valid_d = 1'b0;
    wake_id_d    = '0;
    if (sw_wake_valid_i) begin
      wake_valid_d = 1'b1;
      wake_id_d    = sw_wake_id_i;
    end else if (grant_any) begin
      wake_valid_d         = 1'b1;
      wake_id_d            = map_id_q[grant_idx];
      pending_d[grant_idx] = pending_q[grant_idx] & rise[grant_idx];
      rr_d = (int'(grant_idx) == NUM_IRQ - 1) ? '0 : grant_idx + 1'b1;
    end
    if (map_we_i) pending_d[map_idx_i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q        <= '0;
      pending_q    <= '0;
      map_en_q     <= '0;
      rr_q         <= '0;
      wake_valid_q <= 1'b0;
      wake_id_q    <= '0;
      for (int i = 0; i < NUM_IRQ; i++) map_id_q[i] <= '0;
    end else begin
      irq_q        <= irq_lines_i;
      pending_q    <= pending_d;
      rr_q         <= rr_d;
      wake_valid_q <= wake_valid_d;
      wake_id_q    <= wake_id_d;
      if (map_we_i) begin
        map_en_q[map_idx_i] <= map_en_i;
        map_id_q[map_idx_i] <= map_id_i;
      end
    end
  end

  assign wake_valid_o = wake_valid_q;
  assign wake_id_o    = wake_id_q;

endmodule

// File: rtl/sched_dispatch_ctrl.sv
// CPU-side front end of the EDF scheduler: task registration forwarding,
// wakeup merging and the context-switch / completion handshake.
module sched_dispatch_ctrl
  import sched_pkg::*;
#(
  parameter int MAX_TASKS   = MAX_TASKS_DEF,
  parameter int NUM_IRQ     = 8,
  parameter int ACK_TIMEOUT = 16,
  localparam int TASK_BITS  = $clog2(MAX_TASKS),
  localparam int IRQ_BITS   = $clog2(NUM_IRQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // cfg: a transfer happens on every rising clk edge with cfg_valid && cfg_ready.
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  task_table_input_t    cfg_task,
  input  logic [NUM_IRQ-1:0]   irq_lines,
  input  logic                 map_we,
  input  logic [IRQ_BITS-1:0]  map_idx,
  input  logic                 map_en,
  input  logic [TASK_BITS-1:0] map_id,
  input  logic                 sw_wake_valid,
  input  logic [TASK_BITS-1:0] sw_wake_id,
  output logic                 cpu_switch_req,
  output logic [TASK_BITS-1:0] cpu_switch_id,
  input  logic                 cpu_switch_ack,
  input  logic                 cpu_done_valid,
  input  logic                 cpu_done_ok,
  input  logic [TASK_BITS-1:0] cpu_done_id,
  output logic                 cpu_idle,
  output logic                 ack_err,
  input  logic                 ack_err_clr,
  output task_table_input_t    sched_input_task,
  output logic                 sched_wakeup_valid,
  output logic [TASK_BITS-1:0] sched_wakeup_id,
  output logic                 sched_completion_valid,
  output logic                 sched_completion_successful,
  input  logic [TASK_BITS-1:0] sched_running_task,
  input  logic                 sched_running_valid,
  input  logic                 sched_cpu_interrupt,
  output disp_state_t          dbg_state
);

  localparam int TMR_BITS = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_BITS-1:0] TMR_MAX  = TMR_BITS'(ACK_TIMEOUT);
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(ACK_TIMEOUT - 1);

  disp_state_t          state_q, state_d;
  logic [TASK_BITS-1:0] switch_id_q, switch_id_d, cur_id_q, cur_id_d;
  logic [TMR_BITS-1:0]  timer_q, timer_d;
  logic                 err_q, err_d, err_set;
  logic                 comp_valid_q, comp_valid_d, comp_ok_q, comp_ok_d;
  task_table_input_t    in_task_q, in_task_d;

  assign cfg_ready = rst_n;

  always_comb begin
    in_task_d = '0;
    if (cfg_valid && cfg_ready) begin
      in_task_d       = cfg_task;
      in_task_d.valid = 1'b1;
    end
  end

  sched_wakeup_arb #(.NUM_IRQ(NUM_IRQ), .TASK_BITS(TASK_BITS)) u_wakeup_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq_lines_i     (irq_lines),
    .map_we_i        (map_we),
    .map_idx_i       (map_idx),
    .map_en_i        (map_en),
    .map_id_i        (map_id),
    .sw_wake_valid_i (sw_wake_valid),
    .sw_wake_id_i    (sw_wake_id),
    .wake_valid_o    (sched_wakeup_valid),
    .wake_id_o       (sched_wakeup_id)
  );

  always_comb begin
    state_d      = state_q;
    switch_id_d  = switch_id_q;
    cur_id_d     = cur_id_q;
    timer_d      = timer_q;
    err_set      = 1'b0;
    comp_valid_d = 1'b0;
    comp_ok_d    = 1'b0;
    unique case (state_q)
      DISP_IDLE, DISP_DONE_WAIT: begin
        state_d = DISP_IDLE;
        if (sched_running_valid) begin
          state_d     = DISP_REQ;
          switch_id_d = sched_running_task;
          timer_d     = '0;
        end
      end
      DISP_REQ: begin
        if (!sched_running_valid) begin
          state_d = DISP_IDLE;
        end else if (cpu_switch_ack) begin
          cur_id_d = switch_id_q;
          state_d  = DISP_RUN;
        end else if (sched_running_task != switch_id_q) begin
          switch_id_d = sched_running_task;
          timer_d     = '0;
        end else if (timer_q != TMR_MAX) begin
          // Saturating at the limit keeps ack_err a single set event.
          timer_d = timer_q + 1'b1;
          err_set = (timer_q == TMR_LAST);
        end
      end
      DISP_RUN: begin
        if (!sched_running_valid) begin
          state_d = DISP_IDLE;
        end else if (sched_cpu_interrupt || sched_running_task != cur_id_q) begin
          state_d     = DISP_REQ;
          switch_id_d = sched_running_task;
          timer_d     = '0;
        end else if (cpu_done_valid && cpu_done_id == cur_id_q) begin
          comp_valid_d = 1'b1;
          comp_ok_d    = cpu_done_ok;
          state_d      = DISP_DONE_WAIT;
        end
      end
      default: state_d = DISP_IDLE;
    endcase
    err_d = err_set | (err_q & ~ack_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DISP_IDLE;
      switch_id_q  <= '0;
      cur_id_q     <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      comp_valid_q <= 1'b0;
      comp_ok_q    <= 1'b0;
      in_task_q    <= '0;
    end else begin
      state_q      <= state_d;
      switch_id_q  <= switch_id_d;
      cur_id_q     <= cur_id_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      comp_valid_q <= comp_valid_d;
      comp_ok_q    <= comp_ok_d;
      in_task_q    <= in_task_d;
    end
  end

  assign cpu_switch_req              = (state_q == DISP_REQ);
  assign cpu_switch_id               = cpu_switch_req ? switch_id_q : '0;
  assign cpu_idle                    = (state_q == DISP_IDLE) || (state_q == DISP_DONE_WAIT);
  assign ack_err                     = err_q;
  assign sched_input_task            = in_task_q;
  assign sched_completion_valid      = comp_valid_q;
  assign sched_completion_successful = comp_ok_q;
  assign dbg_state                   = state_q;

endmodule
